dmi_txn_ctrl: RTL and testbench

DMI_TXN_CTRL -- requirements
Module: dmi_txn_ctrl

---
 rtl/dmi_txn_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_dmi_txn_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_txn_ctrl.sv
// dmi_txn_ctrl: bridges an upstream DMI request/response port to a downstream
// debug module. Requests are buffered in a 2-entry FIFO and forwarded one at a
// time, with a response timeout and discard of late downstream responses.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a queued request (blocked while a late reply is owed)
// REQ    | presenting the registered request downstream
// WAIT   | waiting for the downstream response, timeout counter running
// RESP   | presenting the response register upstream
module dmi_txn_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 7,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic [ADDR_WIDTH-1:0] s_q_addr,
    input  logic [1:0]            s_q_op,
    input  logic [31:0]           s_q_data,
    input  logic                  s_q_valid,
    output logic                  s_q_ready,

    output logic [31:0]           s_p_data,
    output logic                  s_p_resp,
    output logic                  s_p_valid,
    input  logic                  s_p_ready,

    output logic [ADDR_WIDTH-1:0] m_q_addr,
    output logic [1:0]            m_q_op,
    output logic [31:0]           m_q_data,
    output logic                  m_q_valid,
    input  logic                  m_q_ready,

    input  logic [31:0]           m_p_data,
    input  logic                  m_p_resp,
    input  logic                  m_p_valid,
    output logic                  m_p_ready,

    input  logic                  err_clr_i,
    output logic                  err_sticky_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [1:0]  OP_NOP   = 2'd0;
    localparam logic [1:0]  OP_READ  = 2'd1;
    localparam logic [1:0]  OP_WRITE = 2'd2;
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] fifo_addr_q [2];
    logic [1:0]            fifo_op_q   [2];
    logic [31:0]           fifo_data_q [2];
    logic                  fifo_wptr_q;
    logic                  fifo_rptr_q;
    logic [1:0]            fifo_cnt_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;

    assign fifo_full  = (fifo_cnt_q == 2'd2);
    assign fifo_empty = (fifo_cnt_q == 2'd0);
    // Gated by rst_ni so the port reads not-ready for the whole reset window
    // yet is ready straight after release.
    assign s_q_ready  = rst_ni & ~fifo_full;
    assign fifo_push  = s_q_valid & s_q_ready;

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            if (fifo_push) fifo_wptr_q <= ~fifo_wptr_q;
            if (fifo_pop)  fifo_rptr_q <= ~fifo_rptr_q;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until the occupancy says otherwise
    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_addr_q[fifo_wptr_q] <= s_q_addr;
            fifo_op_q[fifo_wptr_q]   <= s_q_op;
            fifo_data_q[fifo_wptr_q] <= s_q_data;
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    state_e                state_q,    state_d;
    logic [15:0]           tcnt_q,     tcnt_d;
    logic                  drop_q,     drop_d;
    logic                  err_q,      err_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [1:0]            cur_op_q,   cur_op_d;
    logic [31:0]           cur_data_q, cur_data_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic                  rsp_err_q,  rsp_err_d;
    logic                  err_set;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            tcnt_q     <= 16'd0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            cur_addr_q <= '0;
            cur_op_q   <= 2'd0;
            cur_data_q <= 32'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            cur_addr_q <= cur_addr_d;
            cur_op_q   <= cur_op_d;
            cur_data_q <= cur_data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Next-state, FIFO pop, response capture and sticky error decisions
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        drop_d     = drop_q;
        cur_addr_d = cur_addr_q;
        cur_op_d   = cur_op_q;
        cur_data_d = cur_data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        err_set    = 1'b0;
        fifo_pop   = 1'b0;

        // A late reply owed by a timed-out transaction is swallowed here.
        if (drop_q && m_p_valid) begin
            drop_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !drop_q) begin
                    fifo_pop   = 1'b1;
                    cur_addr_d = fifo_addr_q[fifo_rptr_q];
                    cur_op_d   = fifo_op_q[fifo_rptr_q];
                    cur_data_d = fifo_data_q[fifo_rptr_q];
                    if (fifo_op_q[fifo_rptr_q] == OP_READ ||
                        fifo_op_q[fifo_rptr_q] == OP_WRITE) begin
                        state_d = ST_REQ;
                    end else if (fifo_op_q[fifo_rptr_q] == OP_NOP) begin
                        rsp_data_d = 32'd0;
                        rsp_err_d  = 1'b0;
                        state_d    = ST_RESP;
                    end else begin
                        rsp_data_d = 32'd0;
                        rsp_err_d  = 1'b1;
                        err_set    = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                if (m_q_ready) begin
                    tcnt_d  = 16'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A reply in the expiry cycle still counts as a real reply.
                if (m_p_valid) begin
                    rsp_data_d = m_p_data;
                    rsp_err_d  = m_p_resp;
                    err_set    = m_p_resp;
                    state_d    = ST_RESP;
                end else if (tcnt_q == TO_LAST) begin
                    rsp_data_d = 32'd0;
                    rsp_err_d  = 1'b1;
                    err_set    = 1'b1;
                    drop_d     = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (s_p_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        err_d = err_set | (err_q & ~err_clr_i);
    end

    // ------------------------------------------------------------------
    // Outputs; payloads are held at zero whenever their valid is low
    // ------------------------------------------------------------------
    assign m_q_valid    = (state_q == ST_REQ);
    assign m_q_addr     = m_q_valid ? cur_addr_q : '0;
    assign m_q_op       = m_q_valid ? cur_op_q   : 2'd0;
    assign m_q_data     = m_q_valid ? cur_data_q : 32'd0;

    assign m_p_ready    = (state_q == ST_WAIT) | drop_q;

    assign s_p_valid    = (state_q == ST_RESP);
    assign s_p_data     = s_p_valid ? rsp_data_q : 32'd0;
    assign s_p_resp     = s_p_valid & rsp_err_q;

    assign err_sticky_o = err_q;
    assign busy_o       = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_dmi_txn_ctrl.sv
// Testbench for dmi_txn_ctrl: directed scenarios plus a randomized run, with a
// scoreboard of expected upstream responses and a scripted debug-module model.
module tb_dmi_txn_ctrl;

    localparam int AW = 7;
    localparam int TO = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    op;
        logic [31:0]   data;
        int            dly;
        logic [31:0]   rdata;
        logic          rresp;
    } plan_t;

    typedef struct {
        logic [31:0] data;
        logic        resp;
    } rsp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [AW-1:0] s_q_addr;
    logic [1:0]    s_q_op;
    logic [31:0]   s_q_data;
    logic          s_q_valid;
    logic          s_q_ready;
    logic [31:0]   s_p_data;
    logic          s_p_resp;
    logic          s_p_valid;
    logic          s_p_ready;
    logic [AW-1:0] m_q_addr;
    logic [1:0]    m_q_op;
    logic [31:0]   m_q_data;
    logic          m_q_valid;
    logic          m_q_ready;
    logic [31:0]   m_p_data;
    logic          m_p_resp;
    logic          m_p_valid;
    logic          m_p_ready;
    logic          err_clr_i;
    logic          err_sticky_o;
    logic          busy_o;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    rsp_t  exp_q[$];
    plan_t plan_q[$];
    logic sticky_exp = 1'b0;
    bit   mq_stall = 1'b0;
    bit   dm_mute = 1'b0;
    bit   dm_busy = 1'b0;
    int   acc_cyc = 0;
    int   mq_xfer_cyc = 0;
    int   sp_rise_cyc = 0;
    int   mq_rise_cyc = 0;

    dmi_txn_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_q_addr(s_q_addr), .s_q_op(s_q_op), .s_q_data(s_q_data),
        .s_q_valid(s_q_valid), .s_q_ready(s_q_ready),
        .s_p_data(s_p_data), .s_p_resp(s_p_resp),
        .s_p_valid(s_p_valid), .s_p_ready(s_p_ready),
        .m_q_addr(m_q_addr), .m_q_op(m_q_op), .m_q_data(m_q_data),
        .m_q_valid(m_q_valid), .m_q_ready(m_q_ready),
        .m_p_data(m_p_data), .m_p_resp(m_p_resp),
        .m_p_valid(m_p_valid), .m_p_ready(m_p_ready),
        .err_clr_i(err_clr_i), .err_sticky_o(err_sticky_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bounded wait expired (cycle %0d)", name, cyc);
    endtask

    // Upstream response monitor / scoreboard, idle-payload and rise tracking
    initial begin : mon
        rsp_t e;
        logic sp_prev;
        logic mq_prev;
        sp_prev = 1'b0;
        mq_prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (!m_q_valid) begin
                    chk("mq_idle_addr", 32'(m_q_addr), 32'd0);
                    chk("mq_idle_op",   32'(m_q_op),   32'd0);
                    chk("mq_idle_data", m_q_data,      32'd0);
                end
                if (!s_p_valid) chk("sp_idle_data", s_p_data, 32'd0);
                if (s_p_valid && !sp_prev) sp_rise_cyc = cyc;
                if (m_q_valid && !mq_prev) mq_rise_cyc = cyc;
                if (s_p_valid && s_p_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rsp: got data 0x%08h resp %0d, none outstanding",
                                 s_p_data, s_p_resp);
                    end else begin
                        e = exp_q.pop_front();
                        sticky_exp = sticky_exp | e.resp;
                        chk("rsp_data",   s_p_data,            e.data);
                        chk("rsp_resp",   32'(s_p_resp),       32'(e.resp));
                        chk("rsp_sticky", 32'(err_sticky_o),   32'(sticky_exp));
                    end
                end
            end
            sp_prev = s_p_valid;
            mq_prev = m_q_valid;
        end
    end

    // Debug-module model: checks forwarded requests, replies after a scripted delay
    initial begin : dm
        plan_t p;
        bit    got;
        m_p_valid = 1'b0;
        m_p_data  = 32'd0;
        m_p_resp  = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_ni && m_q_valid && m_q_ready) begin
                mq_xfer_cyc = cyc;
                if (!dm_mute) begin
                    if (plan_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_mq: got addr 0x%02h op %0d, none expected",
                                 m_q_addr, m_q_op);
                    end else begin
                        p = plan_q.pop_front();
                        chk("mq_addr", 32'(m_q_addr), 32'(p.addr));
                        chk("mq_op",   32'(m_q_op),   32'(p.op));
                        chk("mq_data", m_q_data,      p.data);
                        dm_busy = 1'b1;
                        @(posedge clk_i); #1;
                        repeat (p.dly) begin @(posedge clk_i); #1; end
                        m_p_valid = 1'b1;
                        m_p_data  = p.rdata;
                        m_p_resp  = p.rresp;
                        got = 1'b0;
                        for (int i = 0; i < 200; i++) begin
                            @(negedge clk_i);
                            if (m_p_ready) begin got = 1'b1; break; end
                        end
                        if (!got) fail_now("mp_handshake");
                        @(posedge clk_i); #1;
                        m_p_valid = 1'b0;
                        m_p_data  = 32'd0;
                        m_p_resp  = 1'b0;
                        dm_busy   = 1'b0;
                    end
                end
            end
        end
    end

    // Random back-pressure on the two ready inputs
    initial begin : readies
        m_q_ready = 1'b0;
        s_p_ready = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            m_q_ready = mq_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            s_p_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one request until accepted; record its expected outcome
    task automatic send(input logic [AW-1:0] a, input logic [1:0] op, input logic [31:0] d,
                        input int dly, input logic [31:0] rd, input logic rr, input bit track);
        bit    ok;
        plan_t p;
        rsp_t  e;
        s_q_valid = 1'b1;
        s_q_addr  = a;
        s_q_op    = op;
        s_q_data  = d;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_i);
            if (s_q_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            fail_now("send_accept");
        end else begin
            acc_cyc = cyc;
            if (track) begin
                if (op == 2'd0) begin
                    e.data = 32'd0; e.resp = 1'b0;
                end else if (op == 2'd3) begin
                    e.data = 32'd0; e.resp = 1'b1;
                end else begin
                    if (dly <= TO - 1) begin
                        e.data = rd; e.resp = rr;
                    end else begin
                        e.data = 32'd0; e.resp = 1'b1;
                    end
                    p.addr = a; p.op = op; p.data = d;
                    p.dly = dly; p.rdata = rd; p.rresp = rr;
                    plan_q.push_back(p);
                end
                exp_q.push_back(e);
            end
        end
        @(posedge clk_i); #1;
        s_q_valid = 1'b0;
        s_q_addr  = '0;
        s_q_op    = 2'd0;
        s_q_data  = 32'd0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i); #1;
            if (exp_q.size() == 0 && plan_q.size() == 0 && !busy_o && !dm_busy && !m_p_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain");
    endtask

    task automatic clear_sticky();
        err_clr_i = 1'b1;
        @(posedge clk_i); #1;
        err_clr_i = 1'b0;
        sticky_exp = 1'b0;
        @(negedge clk_i);
        chk("sticky_cleared", 32'(err_sticky_o), 32'd0);
        @(posedge clk_i); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sq_ready"}, 32'(s_q_ready),    32'd0);
        chk({tag, "_mq_valid"}, 32'(m_q_valid),    32'd0);
        chk({tag, "_mq_addr"},  32'(m_q_addr),     32'd0);
        chk({tag, "_sp_valid"}, 32'(s_p_valid),    32'd0);
        chk({tag, "_sp_data"},  s_p_data,          32'd0);
        chk({tag, "_sp_resp"},  32'(s_p_resp),     32'd0);
        chk({tag, "_mp_ready"}, 32'(m_p_ready),    32'd0);
        chk({tag, "_busy"},     32'(busy_o),       32'd0);
        chk({tag, "_sticky"},   32'(err_sticky_o), 32'd0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [1:0] op;
        int         r;
        bit         ok;
        s_q_valid = 1'b0;
        s_q_addr  = '0;
        s_q_op    = 2'd0;
        s_q_data  = 32'd0;
        err_clr_i = 1'b0;

        #2;
        check_reset_outputs("rst");
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("ready_after_rst", 32'(s_q_ready), 32'd1);
        @(posedge clk_i); #1;

        // Single read, reply three cycles after the request transfer
        send(7'h11, 2'd1, 32'd0, 3, 32'hDEADBEEF, 1'b0, 1'b1);
        drain();
        chk("rd_latency", 32'(mq_rise_cyc - acc_cyc), 32'd2);
        chk("rd_sticky",  32'(err_sticky_o), 32'd0);

        // Three back-to-back writes against a stalled downstream port
        mq_stall = 1'b1;
        send(7'h20, 2'd2, 32'h0000_A001, 1, 32'd0, 1'b0, 1'b1);
        send(7'h21, 2'd2, 32'h0000_A002, 0, 32'd0, 1'b0, 1'b1);
        send(7'h22, 2'd2, 32'h0000_A003, 2, 32'd0, 1'b0, 1'b1);
        @(negedge clk_i);
        chk("sq_ready_full", 32'(s_q_ready), 32'd0);
        @(posedge clk_i); #1;
        repeat (7) begin @(posedge clk_i); #1; end
        mq_stall = 1'b0;
        drain();

        // Timeout, late reply discard, then normal traffic resumes
        send(7'h30, 2'd1, 32'd0, 10, 32'h1234_5678, 1'b0, 1'b1);
        drain();
        chk("timeout_latency", 32'(sp_rise_cyc - mq_xfer_cyc), 32'(TO + 1));
        chk("timeout_sticky", 32'(err_sticky_o), 32'd1);
        send(7'h31, 2'd1, 32'd0, 2, 32'hCAFE_0001, 1'b0, 1'b1);
        drain();
        send(7'h32, 2'd1, 32'd0, TO - 1, 32'hA5A5_5A5A, 1'b0, 1'b1);
        drain();
        send(7'h33, 2'd2, 32'h0000_0033, TO, 32'h7777_7777, 1'b0, 1'b1);
        drain();
        clear_sticky();
        send(7'h34, 2'd1, 32'd0, 0, 32'h0000_0055, 1'b1, 1'b1);
        drain();
        chk("mresp_sticky", 32'(err_sticky_o), 32'd1);

        // NOP then reserved op, with clear colliding with the set
        clear_sticky();
        send(7'h40, 2'd0, 32'h1111_1111, 0, 32'd0, 1'b0, 1'b1);
        drain();
        chk("nop_latency", 32'(sp_rise_cyc - acc_cyc), 32'd2);
        chk("nop_sticky", 32'(err_sticky_o), 32'd0);
        send(7'h41, 2'd3, 32'h2222_2222, 0, 32'd0, 1'b0, 1'b1);
        err_clr_i = 1'b1;
        @(posedge clk_i); #1;
        err_clr_i = 1'b0;
        @(negedge clk_i);
        chk("sticky_set_wins", 32'(err_sticky_o), 32'd1);
        @(posedge clk_i); #1;
        drain();
        chk("rsv_latency", 32'(sp_rise_cyc - acc_cyc), 32'd2);
        clear_sticky();

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      op = 2'd0;
            else if (r == 1) op = 2'd3;
            else if (r < 6)  op = 2'd1;
            else             op = 2'd2;
            send(AW'($urandom), op, $urandom, $urandom_range(0, 11), $urandom,
                 ($urandom_range(0, 7) == 0), 1'b1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
        end
        drain();

        // Reset while waiting downstream with the FIFO full
        dm_mute = 1'b1;
        send(7'h50, 2'd1, 32'd0, 0, 32'd0, 1'b0, 1'b0);
        send(7'h51, 2'd1, 32'd0, 0, 32'd0, 1'b0, 1'b0);
        send(7'h52, 2'd1, 32'd0, 0, 32'd0, 1'b0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (m_p_ready && !s_q_ready && !s_p_valid) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("reach_wait_full");
        #1;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sticky_exp = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni  = 1'b1;
        dm_mute = 1'b0;
        #1;
        chk("ready_after_midrst", 32'(s_q_ready), 32'd1);
        chk("busy_after_midrst",  32'(busy_o),    32'd0);
        @(posedge clk_i); #1;
        send(7'h5A, 2'd1, 32'd0, 4, 32'h0BAD_F00D, 1'b0, 1'b1);
        drain();
        repeat (5) begin @(posedge clk_i); #1; end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
